// File: rtl/nco_quadrature_pipelined_if.sv
// Control and sample bus of the quadrature NCO: tuning inputs toward the NCO, sine/cosine samples back.
interface nco_quadrature_pipelined_if #(
  parameter int SINE_WIDTH  = 12,
  parameter int PHASE_WIDTH = 32
);
  logic                          sample_clk_ce;
  logic [PHASE_WIDTH-1:0]        phase_increment;
  logic                          inc_load;
  logic [PHASE_WIDTH-1:0]        phase_offset;
  logic                          phase_sync;
  logic                          out_valid;
  logic signed [SINE_WIDTH-1:0]  sinewave;
  logic signed [SINE_WIDTH-1:0]  cosinewave;

  modport master (
    output sample_clk_ce, phase_increment, inc_load, phase_offset, phase_sync,
    input  out_valid, sinewave, cosinewave
  );

  modport slave (
    input  sample_clk_ce, phase_increment, inc_load, phase_offset, phase_sync,
    output out_valid, sinewave, cosinewave
  );
endinterface

// File: rtl/nco_quadrature_pipelined.sv
// Phase-accumulator NCO with registered sine/cosine from one quarter-wave table, 3-cycle pipeline.
// Build macro NCO_PHASE_DITHER_EN adds LFSR phase dither just below the table address.
module nco_quadrature_pipelined #(
  parameter int SINE_WIDTH  = 12,
  parameter int LUT_WIDTH   = 10,
  parameter int PHASE_WIDTH = 32
) (
  input logic                        clk,
  input logic                        arst,
  nco_quadrature_pipelined_if.slave  bus
);
  localparam int QW  = LUT_WIDTH - 2;
  localparam int N   = 1 << QW;
  localparam int AMP = (1 << (SINE_WIDTH - 1)) - 1;

  // Half-step sample points keep every entry non-zero and make the fold exactly symmetric.
  function automatic int tab_val(int k);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << LUT_WIDTH);
    return $rtoi(real'(AMP) * $sin(ang) + 0.5);
  endfunction

  logic [SINE_WIDTH-2:0] qtab [N];
  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam int TV = tab_val(k);
    assign qtab[k] = TV[SINE_WIDTH-2:0];
  end

  logic [PHASE_WIDTH-1:0]       acc;
  logic [PHASE_WIDTH-1:0]       inc_active;
  logic [PHASE_WIDTH-1:0]       dith_add;
  logic [LUT_WIDTH-1:0]         a_now;
  logic [LUT_WIDTH-1:0]         addr_s;
  logic [LUT_WIDTH-1:0]         addr_c;
  logic                         v1;
  logic                         v2;
  logic [SINE_WIDTH-2:0]        mag_s;
  logic [SINE_WIDTH-2:0]        mag_c;
  logic                         neg_s;
  logic                         neg_c;
  logic signed [SINE_WIDTH-1:0] sin_pos;
  logic signed [SINE_WIDTH-1:0] cos_pos;

`ifdef NCO_PHASE_DITHER_EN
  localparam int DW = (PHASE_WIDTH - LUT_WIDTH < 16) ? (PHASE_WIDTH - LUT_WIDTH) : 16;
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (arst)
      lfsr <= 16'hACE1;
    else if (bus.sample_clk_ce)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  if (DW > 0) begin : g_dith
    assign dith_add = PHASE_WIDTH'(lfsr[DW-1:0]) << (PHASE_WIDTH - LUT_WIDTH - DW);
  end else begin : g_no_dith
    assign dith_add = '0;
  end
`else
  assign dith_add = '0;
`endif

  // Sync zeroes the phase of the sample taken on the same edge, not only the next one.
  assign a_now = LUT_WIDTH'(((bus.phase_sync ? '0 : acc) + bus.phase_offset + dith_add)
                            >> (PHASE_WIDTH - LUT_WIDTH));

  always_ff @(posedge clk) begin
    if (arst) begin
      acc        <= '0;
      inc_active <= '0;
    end else begin
      if (bus.inc_load)
        inc_active <= bus.phase_increment;
      if (bus.phase_sync)
        acc <= '0;
      else if (bus.sample_clk_ce)
        acc <= acc + inc_active;
    end
  end

  assign sin_pos = {1'b0, mag_s};
  assign cos_pos = {1'b0, mag_c};

  always_ff @(posedge clk) begin
    if (arst) begin
      addr_s         <= '0;
      addr_c         <= '0;
      v1             <= 1'b0;
      mag_s          <= '0;
      mag_c          <= '0;
      neg_s          <= 1'b0;
      neg_c          <= 1'b0;
      v2             <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.sinewave   <= '0;
      bus.cosinewave <= '0;
    end else begin
      v1 <= bus.sample_clk_ce;
      if (bus.sample_clk_ce) begin
        addr_s <= a_now;
        addr_c <= a_now + LUT_WIDTH'(N);
      end
      // Odd quadrants read the table mirrored: N-1-i is the bitwise inverse of i.
      v2    <= v1;
      mag_s <= qtab[addr_s[QW] ? ~addr_s[QW-1:0] : addr_s[QW-1:0]];
      mag_c <= qtab[addr_c[QW] ? ~addr_c[QW-1:0] : addr_c[QW-1:0]];
      neg_s <= addr_s[LUT_WIDTH-1];
      neg_c <= addr_c[LUT_WIDTH-1];
      bus.out_valid <= v2;
      if (v2) begin
        bus.sinewave   <= neg_s ? -sin_pos : sin_pos;
        bus.cosinewave <= neg_c ? -cos_pos : cos_pos;
      end
    end
  end
endmodule

// File: tb/tb_nco_quadrature_pipelined.sv
// Directed bench for the quadrature NCO: table of tuning scenarios plus latency, load, and reset sequences.
module tb_nco_quadrature_pipelined;
  localparam int SW = 12;
  localparam int LW = 10;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  nco_quadrature_pipelined_if #(.SINE_WIDTH(SW), .PHASE_WIDTH(PW)) bus();
  nco_quadrature_pipelined #(.SINE_WIDTH(SW), .LUT_WIDTH(LW), .PHASE_WIDTH(PW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] c;
  } samp_t;
  samp_t got_q[$];

  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1)
      got_q.push_back('{s: bus.sinewave, c: bus.cosinewave});
  end

  typedef struct {
    string       name;
    logic [PW-1:0] inc;
    logic [PW-1:0] off;
    bit          sync;
    int          es[4];
    int          ec[4];
  } vec_t;
  vec_t vecs[6];

  bit ce_hist[32];
  int seq_sin[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.sample_clk_ce = 1'b0;
    bus.inc_load      = 1'b0;
    bus.phase_sync    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    bus.phase_offset    = '0;
    bus.phase_increment = '0;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    got_q.delete();
  endtask

  task automatic load_inc(input logic [PW-1:0] inc);
    bus.inc_load        = 1'b1;
    bus.phase_increment = inc;
    @(negedge clk);
    bus.inc_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_v;
    int idx;

    vecs[0] = '{"quarter",   32'h4000_0000, 32'h0000_0000, 1'b0, '{6, 2047, -6, -2047}, '{2047, -6, -2047, 6}};
    vecs[1] = '{"wrap",      32'hC000_0000, 32'h0000_0000, 1'b0, '{6, -2047, -6, 2047}, '{2047, 6, -2047, -6}};
    vecs[2] = '{"offs_sync", 32'h0000_0000, 32'h8000_0000, 1'b1, '{-6, -6, -6, -6}, '{-2047, -2047, -2047, -2047}};
    vecs[3] = '{"half_offs", 32'h8000_0000, 32'h4000_0000, 1'b0, '{2047, -2047, 2047, -2047}, '{-6, 6, -6, 6}};
    vecs[4] = '{"fine_step", 32'h0040_0000, 32'h0000_0000, 1'b0, '{6, 19, 31, 44}, '{2047, 2047, 2047, 2047}};
    vecs[5] = '{"mid_table", 32'h8000_0000, 32'h2000_0000, 1'b0, '{1452, -1452, 1452, -1452}, '{1443, -1443, 1443, -1443}};

    // Reset state
    arst = 1'b1;
    drive_idle();
    bus.phase_offset    = '0;
    bus.phase_increment = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset sinewave", int'(bus.sinewave), 0);
    check("reset cosinewave", int'(bus.cosinewave), 0);
    arst = 1'b0;

    // Table-driven scenarios: four back-to-back samples each
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_inc(vecs[v].inc);
      bus.phase_offset = vecs[v].off;
      for (int k = 0; k < 4; k++) begin
        bus.sample_clk_ce = 1'b1;
        bus.phase_sync    = (k == 0) && vecs[v].sync;
        @(negedge clk);
      end
      drive_idle();
      repeat (8) @(negedge clk);
      check({vecs[v].name, " count"}, got_q.size(), 4);
      for (int k = 0; k < 4 && k < got_q.size(); k++) begin
        check($sformatf("%s sin[%0d]", vecs[v].name, k), int'(got_q[k].s), vecs[v].es[k]);
        check($sformatf("%s cos[%0d]", vecs[v].name, k), int'(got_q[k].c), vecs[v].ec[k]);
      end
    end

    // Latency and strobe: ce every 5 cycles, strobe exactly 3 cycles after each, outputs held between
    seq_sin = '{6, 2047, -6, -2047};
    do_reset();
    load_inc(32'h4000_0000);
    idx = 0;
    for (int n = 0; n < 26; n++) begin
      ce_hist[n] = (n % 5 == 0) && (n < 20);
      bus.sample_clk_ce = ce_hist[n];
      @(negedge clk);
      exp_v = (n >= 2) ? int'(ce_hist[n-2]) : 0;
      check($sformatf("strobe cyc%0d", n), int'(bus.out_valid), exp_v);
      if (exp_v == 1) begin
        check($sformatf("strobe sin%0d", idx), int'(bus.sinewave), seq_sin[idx]);
        idx++;
      end else begin
        check($sformatf("hold cyc%0d", n), int'(bus.sinewave), (idx == 0) ? 0 : seq_sin[idx-1]);
      end
    end
    drive_idle();

    // Load coinciding with ce still uses the old increment
    do_reset();
    bus.inc_load        = 1'b1;
    bus.phase_increment = 32'h4000_0000;
    bus.sample_clk_ce   = 1'b1;
    @(negedge clk);
    bus.inc_load = 1'b0;
    repeat (2) @(negedge clk);
    drive_idle();
    repeat (8) @(negedge clk);
    check("load count", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      check("load sin0", int'(got_q[0].s), 6);
      check("load sin1", int'(got_q[1].s), 6);
      check("load sin2", int'(got_q[2].s), 2047);
    end

    // Reset mid-stream discards in-flight samples and restarts the accumulator
    do_reset();
    load_inc(32'h4000_0000);
    bus.sample_clk_ce = 1'b1;
    repeat (3) @(negedge clk);
    bus.sample_clk_ce = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    check("midrst out_valid", int'(bus.out_valid), 0);
    check("midrst sinewave", int'(bus.sinewave), 0);
    check("midrst cosinewave", int'(bus.cosinewave), 0);
    arst = 1'b0;
    got_q.delete();
    repeat (8) @(negedge clk);
    check("midrst no strobe", got_q.size(), 0);
    load_inc(32'h4000_0000);
    bus.sample_clk_ce = 1'b1;
    @(negedge clk);
    drive_idle();
    repeat (8) @(negedge clk);
    check("restart count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("restart sin", int'(got_q[0].s), 6);
      check("restart cos", int'(got_q[0].c), 2047);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nco_quadrature_pipelined.md
Name: nco_quadrature_pipelined

Overview:
- Multi-feature successor to the single-rate LUT sine generator.
- Phase-accumulator NCO that produces registered quadrature outputs (sine and cosine) from a single quarter-wave LUT.
- Adds a programmable phase offset, glitch-free frequency load, phase resynchronisation and an output-valid strobe.
- Sits between the control/config logic and the digital mixer in the SDR receive chain.

Parameters:
- SINE_WIDTH, 12: signed output sample width, at least 4.
- LUT_WIDTH, 10: full-cycle address bits. The stored table holds 2^(LUT_WIDTH-2) entries. At least 4, and at most PHASE_WIDTH.
- PHASE_WIDTH, 32: phase accumulator, increment and offset width.

Ports:
- clk, input, 1: system clock.
- arst, input, 1: synchronous active-high reset, sampled on the clk rising edge.
- sample_clk_ce, input, 1: sample-rate clock enable; one output sample per asserted cycle.
- phase_increment, input, PHASE_WIDTH: unsigned tuning word; captured only when inc_load=1.
- inc_load, input, 1: load strobe for phase_increment.
- phase_offset, input, PHASE_WIDTH: unsigned phase offset; sampled every ce cycle, no latching.
- phase_sync, input, 1: clear the accumulator; used for multi-NCO alignment.
- out_valid, output, 1: one-cycle strobe marking new sinewave/cosinewave values.
- sinewave, output, SINE_WIDTH: signed sine sample, registered.
- cosinewave, output, SINE_WIDTH: signed cosine sample, registered.

Behaviour:
- Reset (arst=1 at a clk edge):
  - acc, inc_active and all pipeline registers are cleared.
  - out_valid=0, sinewave=0, cosinewave=0.
  - Reset overrides every other input. Asserting it mid-stream discards in-flight samples; no out_valid follows.
- Increment register:
  - On an edge with inc_load=1, inc_active <= phase_increment.
  - The new value takes effect at the first ce edge strictly after the load.
  - If inc_load and sample_clk_ce are asserted in the same cycle, that ce still uses the old inc_active.
- Accumulator:
  - On a ce edge, acc <= acc + inc_active, modulo 2^PHASE_WIDTH (wraps silently).
  - phase_sync=1 at any edge sets acc <= 0 and takes priority over the ce update.
- Sample phase: the phase sampled at a ce edge is p = (phase_sync ? 0 : acc) + phase_offset, modulo 2^PHASE_WIDTH.
- Address: a = p[PHASE_WIDTH-1 -: LUT_WIDTH], truncated with no rounding.
- Pipeline (latency 3 cycles; out_valid pulses for exactly one cycle):
  - Stage 1, at the ce edge: register the sine address a and the cosine address a+2^(LUT_WIDTH-2) (mod 2^LUT_WIDTH); v1 <= 1. When ce=0, v1 <= 0.
  - Stage 2: register the quarter-table reads and the two quadrant bits per channel; v2 <= v1.
  - Stage 3: apply quadrant fold and sign, register the outputs; out_valid <= v2.
- Back-to-back ce: one sample per cycle; the pipeline never stalls.
- Output hold: outputs keep their last value while out_valid=0.
- Quarter table:
  - N = 2^(LUT_WIDTH-2), A = 2^(SINE_WIDTH-1)-1.
  - T[k] = round(A*sin(2*pi*(k+0.5)/2^LUT_WIDTH)) for k = 0..N-1.
  - Generated at elaboration; no external table module.
- Quadrant fold, with q = a[LUT_WIDTH-1:LUT_WIDTH-2] and i = the low LUT_WIDTH-2 bits:
  - q=0: +T[i]
  - q=1: +T[N-1-i]
  - q=2: -T[i]
  - q=3: -T[N-1-i]
- Range: output magnitude never exceeds A, so -2^(SINE_WIDTH-1) is never produced and the output is symmetric.

Optional Feature:
- Macro: NCO_PHASE_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances on each ce edge.
  - Its low min(16, PHASE_WIDTH-LUT_WIDTH) bits are added to p at the bit positions directly below the address, before truncation.
  - The effect is spur reduction.
- When undefined: no LFSR exists and p is used unmodified. All Test Plan values assume the macro is undefined.

Test Plan:
- Quarter-step sequence: reset; inc_load with 32'h4000_0000; offset 0; ce held high. The first four out_valid pulses give sin = 6, 2047, -6, -2047 and cos = 2047, -6, -2047, 6, with the first pulse 3 cycles after the first ce.
- Latency and strobe: ce pulsed once every 5 cycles. Exactly one out_valid per ce, 3 cycles later; outputs stable between pulses.
- Load timing: inc_load with 32'h4000_0000 in the same cycle as ce, starting from inc_active=0. That sample sits at address 0; the next sample is also address 0; the following one is address 256 (sin 2047).
- Phase offset and sync: offset 32'h8000_0000, inc 0, phase_sync pulsed with ce. Output sin=-6, cos=-2047, repeated every ce.
- Wrap-around: inc 32'hC000_0000. The sample sequence is address 0, 768, 512, 256; sin = 6, -2047, -6, 2047.
- Reset mid-stream: arst asserted one cycle after a ce. No out_valid follows; outputs read 0 on the next cycle; acc restarts from 0.
